timer_controller: RTL and testbench

TIMER_CONTROLLER -- requirements
Module: timer_controller

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_controller_bcd_down_digit.sv | 43 ++++
 rtl/timer_controller.sv | 132 +++++++++++++
 tb/tb_timer_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants, state encoding and preset clamping for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // Largest legal value of each BCD digit position.
  localparam logic [3:0] MIN_MAX   = 4'd2;
  localparam logic [3:0] STENS_MAX = 4'd5;
  localparam logic [3:0] DEC_MAX   = 4'd9;

  localparam int unsigned NUM_DIGITS = 5;

  // Saturate an out-of-range preset digit to the position's maximum.
  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/timer_controller_bcd_down_digit.sv
// One BCD down-counting digit of the borrow chain; wraps 0 -> MAX_VAL on borrow.
import timer_pkg::*;

module bcd_down_digit #(
  parameter logic [3:0] MAX_VAL = 4'd9
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_en_i,
  input  logic       borrow_i,
  output logic       borrow_o,
  output logic [3:0] digit_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: load wins, otherwise step down when this position is asked to borrow.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (dec_en_i && borrow_i) begin
      digit_d = (digit_q == 4'd0) ? MAX_VAL : (digit_q - 4'd1);
    end
  end

  // Digit register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  // A borrow ripples upward only through digits that are currently zero.
  assign borrow_o = borrow_i && (digit_q == 4'd0);
  assign digit_o  = digit_q;

endmodule

// File: rtl/timer_controller.sv
// M:SS.cc countdown timer: request arbitration, FSM and a five-digit BCD borrow chain.
import timer_pkg::*;

module timer_controller (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic       start_i,
  input  logic       pause_toggle_i,
  input  logic [1:0] preset_min_i,
  input  logic [2:0] preset_sec_tens_i,
  input  logic [3:0] preset_sec_ones_i,
  output logic [3:0] digit4_o,
  output logic [3:0] digit3_o,
  output logic [3:0] digit2_o,
  output logic [3:0] digit1_o,
  output logic [3:0] digit0_o,
  output logic [1:0] state_o,
  output logic       running_o,
  output logic       done_pulse_o
);

  // Per-position maxima, index 0 = centisecond ones ... index 4 = minutes.
  localparam logic [4*NUM_DIGITS-1:0] DIGIT_MAX = {MIN_MAX, STENS_MAX, DEC_MAX, DEC_MAX, DEC_MAX};

  state_e     state_q;
  state_e     state_d;
  logic       running_q;
  logic       running_d;
  logic       done_q;
  logic       done_d;
  logic       load_en;
  logic       dec_en;

  logic [3:0]            load_val [NUM_DIGITS];
  logic [3:0]            digit_w  [NUM_DIGITS];
  logic [NUM_DIGITS:0]   borrow_w;

  logic value_is_zero;
  logic value_is_one;

  // Clamped preset goes to M, S tens, S ones; centiseconds always load as zero.
  assign load_val[4] = clamp_digit({2'b00, preset_min_i}, MIN_MAX);
  assign load_val[3] = clamp_digit({1'b0, preset_sec_tens_i}, STENS_MAX);
  assign load_val[2] = clamp_digit(preset_sec_ones_i, DEC_MAX);
  assign load_val[1] = 4'd0;
  assign load_val[0] = 4'd0;

  // The lowest digit always decrements when the chain is enabled.
  assign borrow_w[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_down_digit #(
        .MAX_VAL(DIGIT_MAX[gi*4 +: 4])
      ) u_digit (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (load_en),
        .load_val_i (load_val[gi]),
        .dec_en_i   (dec_en),
        .borrow_i   (borrow_w[gi]),
        .borrow_o   (borrow_w[gi+1]),
        .digit_o    (digit_w[gi])
      );
    end
  endgenerate

  assign value_is_zero = (digit_w[4] == 4'd0) && (digit_w[3] == 4'd0) && (digit_w[2] == 4'd0) &&
                         (digit_w[1] == 4'd0) && (digit_w[0] == 4'd0);
  assign value_is_one  = (digit_w[4] == 4'd0) && (digit_w[3] == 4'd0) && (digit_w[2] == 4'd0) &&
                         (digit_w[1] == 4'd0) && (digit_w[0] == 4'd1);

  // Arbitration and next state: only the highest-priority asserted request is
  // considered; if it has no effect in the current state the cycle is a no-op.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    dec_en  = 1'b0;
    done_d  = 1'b0;
    if (load_i) begin
      if (state_q != ST_RUNNING) begin
        load_en = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (pause_toggle_i) begin
      if (state_q == ST_RUNNING) begin
        state_d = ST_PAUSED;
      end else if (state_q == ST_PAUSED) begin
        state_d = ST_RUNNING;
      end
    end else if (start_i) begin
      if ((state_q == ST_IDLE) && !value_is_zero) begin
        state_d = ST_RUNNING;
      end
    end else if (tick_i) begin
      if (state_q == ST_RUNNING) begin
        dec_en = 1'b1;
        // Last centisecond: the chain lands on zero on this same edge.
        if (value_is_one) begin
          state_d = ST_EXPIRED;
          done_d  = 1'b1;
        end
      end
    end
    running_d = (state_d == ST_RUNNING);
  end

  // State and registered status outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign digit4_o     = digit_w[4];
  assign digit3_o     = digit_w[3];
  assign digit2_o     = digit_w[2];
  assign digit1_o     = digit_w[1];
  assign digit0_o     = digit_w[0];
  assign state_o      = state_q;
  assign running_o    = running_q;
  assign done_pulse_o = done_q;

endmodule

// File: tb/tb_timer_controller.sv
// Self-checking bench: centisecond-count reference model, directed scenarios, random traffic.
module tb_timer_controller;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       load;
  logic       start;
  logic       pause_toggle;
  logic [1:0] preset_min;
  logic [2:0] preset_sec_tens;
  logic [3:0] preset_sec_ones;
  logic [3:0] d4, d3, d2, d1, d0;
  logic [1:0] state;
  logic       running;
  logic       done_pulse;
  logic [19:0] dut_digits;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: value kept as a plain centisecond count.
  int  exp_cs    = 0;
  int  exp_state = 0;
  bit  exp_done  = 0;
  bit  check_en  = 0;

  timer_controller dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .tick_i           (tick),
    .load_i           (load),
    .start_i          (start),
    .pause_toggle_i   (pause_toggle),
    .preset_min_i     (preset_min),
    .preset_sec_tens_i(preset_sec_tens),
    .preset_sec_ones_i(preset_sec_ones),
    .digit4_o         (d4),
    .digit3_o         (d3),
    .digit2_o         (d2),
    .digit1_o         (d1),
    .digit0_o         (d0),
    .state_o          (state),
    .running_o        (running),
    .done_pulse_o     (done_pulse)
  );

  assign dut_digits = {d4, d3, d2, d1, d0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [19:0] cs_to_bcd(input int v);
    int m, s, c;
    m = v / 6000;
    s = (v / 100) % 60;
    c = v % 100;
    return {4'(m), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // Model update for one clock edge, from the inputs held across that edge.
  task automatic model_step();
    int pm, pt, po;
    exp_done = 0;
    if (reset) begin
      exp_cs = 0;
      exp_state = 0;
    end else if (load) begin
      if (exp_state != 1) begin
        pm = (preset_min > 2) ? 2 : int'(preset_min);
        pt = (preset_sec_tens > 5) ? 5 : int'(preset_sec_tens);
        po = (preset_sec_ones > 9) ? 9 : int'(preset_sec_ones);
        exp_cs = pm * 6000 + pt * 1000 + po * 100;
        exp_state = 0;
      end
    end else if (pause_toggle) begin
      if (exp_state == 1) exp_state = 2;
      else if (exp_state == 2) exp_state = 1;
    end else if (start) begin
      if (exp_state == 0 && exp_cs != 0) exp_state = 1;
    end else if (tick) begin
      if (exp_state == 1) begin
        exp_cs = exp_cs - 1;
        if (exp_cs == 0) begin
          exp_state = 3;
          exp_done = 1;
        end
      end
    end
  endtask

  task automatic do_cycle(input bit r, input bit ld, input bit pt, input bit st, input bit tk);
    reset = r; load = ld; pause_toggle = pt; start = st; tick = tk;
    @(posedge clock);
    model_step();
    #1;
    reset = 0; load = 0; pause_toggle = 0; start = 0; tick = 0;
  endtask

  task automatic set_preset(input logic [1:0] m, input logic [2:0] t, input logic [3:0] o);
    preset_min = m; preset_sec_tens = t; preset_sec_ones = o;
  endtask

  // Literal expectation, independent of the model.
  task automatic check(input string name, input logic [19:0] actual, input logic [19:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end else begin
      $display("ok   %s: %h", name, actual);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (check_en) begin
      n_compared++;
      if (dut_digits !== cs_to_bcd(exp_cs) || state !== 2'(exp_state) ||
          running !== (exp_state == 1) || done_pulse !== exp_done) begin
        n_mismatched++;
        $display("FAIL model t=%0t: digits=%h state=%0d run=%b done=%b expected digits=%h state=%0d run=%b done=%b",
                 $time, dut_digits, state, running, done_pulse,
                 cs_to_bcd(exp_cs), exp_state, (exp_state == 1), exp_done);
      end
    end
  end

  initial begin
    reset = 0; load = 0; start = 0; pause_toggle = 0; tick = 0;
    set_preset(2'd0, 3'd0, 4'd0);
    @(posedge clock); #1;

    // Reset state.
    do_cycle(1, 0, 0, 0, 0);
    check_en = 1;
    check("reset_digits", dut_digits, 20'h00000);
    check("reset_status", {16'd0, state, running, done_pulse}, 20'h00000);

    // 0:01 runs out after 100 ticks.
    set_preset(2'd0, 3'd0, 4'd1);
    do_cycle(0, 1, 0, 0, 0);
    check("load_0_01", dut_digits, 20'h00100);
    do_cycle(0, 0, 0, 1, 0);
    check("start_running", {18'd0, state}, 20'd1);
    do_cycle(0, 0, 0, 0, 1);
    check("first_tick", dut_digits, 20'h00099);
    for (int i = 0; i < 98; i++) do_cycle(0, 0, 0, 0, 1);
    check("before_expiry", dut_digits, 20'h00001);
    do_cycle(0, 0, 0, 0, 1);
    check("expiry", {dut_digits[15:0], state, running, done_pulse}, 20'h0000_d);
    do_cycle(0, 0, 0, 0, 1);
    check("expired_hold", {dut_digits[15:0], state, running, done_pulse}, 20'h0000_c);

    // Full borrow chain from 2:00.
    set_preset(2'd2, 3'd0, 4'd0);
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 1);
    check("borrow_chain", dut_digits, 20'h15999);

    // Pause with a concurrent tick.
    do_cycle(1, 0, 0, 0, 0);
    set_preset(2'd0, 3'd3, 4'd0);
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    do_cycle(0, 0, 1, 0, 1);
    check("pause_tick", {dut_digits[15:0], 2'b00, state}, 20'h3000_2);
    for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 0, 1);
    check("paused_ticks", dut_digits, 20'h03000);
    do_cycle(0, 0, 1, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    check("resume_tick", dut_digits, 20'h02999);

    // Load ignored while running.
    do_cycle(0, 1, 0, 0, 1);
    check("load_in_running", {dut_digits[15:0], 2'b00, state}, 20'h2999_1);

    // Clamping.
    do_cycle(1, 0, 0, 0, 0);
    set_preset(2'd3, 3'd7, 4'd12);
    do_cycle(0, 1, 0, 0, 0);
    check("clamp", dut_digits, 20'h25900);

    // Zero preset cannot start.
    set_preset(2'd0, 3'd0, 4'd0);
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 1);
    check("zero_start", {16'd0, state, running, done_pulse}, 20'h00000);

    // Reset with a tick while running at 1:15.40.
    set_preset(2'd1, 3'd1, 4'd6);
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 60; i++) do_cycle(0, 0, 0, 0, 1);
    check("at_1_15_40", dut_digits, 20'h11540);
    do_cycle(1, 0, 0, 0, 1);
    check("reset_abort", {dut_digits[15:0], state, running, done_pulse}, 20'h00000);

    // Random traffic against the model; short presets so expiry happens often.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_preset(2'($urandom), 3'($urandom), 4'($urandom));
      else
        set_preset(2'd0, 3'd0, 4'($urandom_range(0, 2)));
      do_cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) != 0);
    end

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
